// File: rtl/lx32_seq_ctrl.sv
// Multi-cycle control sequencer for the lx32 RV32I core: owns the instruction
// register, runs FETCH/DECODE/EXEC/MEM/WB and guards memory handshakes with a watchdog.
module lx32_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        branch_cond,
  output logic [31:0] ir_o,
  output logic [2:0]  imm_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  wb_sel,
  output logic        rf_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        instret,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam bit               WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t           state, state_nx;
  logic [31:0]      ir;
  logic [CNT_W-1:0] cnt;
  logic             illegal_q, bus_err_q;
  logic             ir_ld, set_ill, set_berr, wait_inc;

  logic [6:0] opc;
  logic       is_load, is_store, is_opimm, is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic       legal, rd_nz, tmo_hit;

  assign opc       = ir[6:0];
  assign is_load   = (opc == OPC_LOAD);
  assign is_store  = (opc == OPC_STORE);
  assign is_opimm  = (opc == OPC_OPIMM);
  assign is_lui    = (opc == OPC_LUI);
  assign is_auipc  = (opc == OPC_AUIPC);
  assign is_jal    = (opc == OPC_JAL);
  assign is_jalr   = (opc == OPC_JALR);
  assign is_branch = (opc == OPC_BRANCH);
  assign legal     = (ir[1:0] == 2'b11) &&
                     (is_load | is_store | is_opimm | is_lui |
                      is_auipc | is_jal | is_jalr | is_branch);
  assign rd_nz     = (ir[11:7] != 5'd0);
  assign tmo_hit   = WD_EN && (cnt == TMO);

  // Datapath steering depends only on the held instruction, never on state
  always_comb begin
    imm_sel   = 3'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    wb_sel    = 2'd0;
    if (is_store)               imm_sel = 3'd1;
    else if (is_branch)         imm_sel = 3'd2;
    else if (is_lui | is_auipc) imm_sel = 3'd3;
    else if (is_jal)            imm_sel = 3'd4;
    alu_a_sel = is_auipc | is_jal | is_branch;
    alu_b_sel = legal;
    if (is_load)               wb_sel = 2'd1;
    else if (is_jal | is_jalr) wb_sel = 2'd2;
  end

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    instret  = 1'b0;
    ir_ld    = 1'b0;
    set_ill  = 1'b0;
    set_berr = 1'b0;
    wait_inc = 1'b0;
    case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_ld    = 1'b1;
          state_nx = S_DECODE;
        end else if (tmo_hit) begin
          set_berr = 1'b1;
          state_nx = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_nx = S_EXEC;
        end else begin
          set_ill  = 1'b1;
          state_nx = S_HALT;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_we    = 1'b1;
          pc_sel   = branch_cond;
          instret  = 1'b1;
          state_nx = S_FETCH;
        end else if (is_load | is_store) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            pc_we    = 1'b1;
            instret  = 1'b1;
            state_nx = S_FETCH;
          end else begin
            state_nx = S_WB;
          end
        end else if (tmo_hit) begin
          set_berr = 1'b1;
          state_nx = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        rf_we    = rd_nz;
        pc_we    = 1'b1;
        pc_sel   = is_jal | is_jalr;
        instret  = 1'b1;
        state_nx = S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  // Wait counter restarts whenever the FSM moves, so each handshake gets a fresh budget
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ir        <= '0;
      cnt       <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (ir_ld)    ir        <= imem_rdata;
      if (set_ill)  illegal_q <= 1'b1;
      if (set_berr) bus_err_q <= 1'b1;
      if (state_nx != state) cnt <= '0;
      else if (wait_inc)     cnt <= sat_inc(cnt);
    end
  end

  assign ir_o    = ir;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign state_o = state;

endmodule

// File: tb/tb_lx32_seq_ctrl.sv
// Bench for lx32_seq_ctrl: directed RV32I sequences plus random instruction
// streams compared against a per-instruction latency/strobe-count model.
module tb_lx32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, branch_cond;
  logic [31:0] imem_rdata, ir_o;
  logic [2:0]  imm_sel, state_o;
  logic        alu_a_sel, alu_b_sel, rf_we, pc_we, pc_sel, instret, illegal, bus_err;
  logic [1:0]  wb_sel;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int         cycles, n_ireq, n_dreq, n_dwe, n_rfwe;
    logic [2:0] imm;
    logic       a, b, pcsel;
    logic [1:0] wb;
  } exp_t;

  typedef struct {
    int          cycles, n_ireq, n_dreq, n_dwe, n_rfwe, n_pcwe, n_inst, sel_bad;
    logic        pcsel, tmo;
    logic [31:0] ir, hist;
  } obs_t;

  lx32_seq_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .branch_cond(branch_cond), .ir_o(ir_o), .imm_sel(imm_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .instret(instret),
    .illegal(illegal), .bus_err(bus_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // Expected behaviour of one instruction, straight from the ISA-level rules
  function automatic exp_t model(input logic [31:0] in, input int iw, input int dw, input logic bc);
    exp_t e;
    int   rdw;
    rdw = (in[11:7] != 5'd0) ? 1 : 0;
    e = '{cycles: 4 + iw, n_ireq: iw + 1, n_dreq: 0, n_dwe: 0, n_rfwe: 0,
          imm: 3'd0, a: 1'b0, b: 1'b1, pcsel: 1'b0, wb: 2'd0};
    case (in[6:0])
      7'h63: begin e.cycles = 3 + iw; e.imm = 3'd2; e.a = 1'b1; e.pcsel = bc; end
      7'h03: begin e.cycles = 5 + iw + dw; e.n_dreq = dw + 1; e.wb = 2'd1; e.n_rfwe = rdw; end
      7'h23: begin e.cycles = 4 + iw + dw; e.n_dreq = dw + 1; e.n_dwe = dw + 1; e.imm = 3'd1; end
      7'h13: e.n_rfwe = rdw;
      7'h37: begin e.imm = 3'd3; e.n_rfwe = rdw; end
      7'h17: begin e.imm = 3'd3; e.a = 1'b1; e.n_rfwe = rdw; end
      7'h6F: begin e.imm = 3'd4; e.a = 1'b1; e.wb = 2'd2; e.pcsel = 1'b1; e.n_rfwe = rdw; end
      7'h67: begin e.wb = 2'd2; e.pcsel = 1'b1; e.n_rfwe = rdw; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = '0; branch_cond = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one instruction from its first FETCH cycle to retirement and records what was seen
  task automatic run_instr(input logic [31:0] in, input int iw, input int dw,
                           input logic bc, input exp_t e, output obs_t o);
    int   ic, dc;
    logic done;
    logic [2:0] st;
    ic = 0; dc = 0; done = 1'b0;
    o = '{cycles: 0, n_ireq: 0, n_dreq: 0, n_dwe: 0, n_rfwe: 0, n_pcwe: 0, n_inst: 0,
          sel_bad: 0, pcsel: 1'b0, tmo: 1'b0, ir: '0, hist: '0};
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      st = state_o;
      imem_ready  = 1'($urandom_range(0, 1));
      dmem_ready  = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      branch_cond = (st == 3'd3) ? bc : 1'($urandom_range(0, 1));
      if (st == 3'd1) begin
        imem_ready = (ic == iw);
        if (ic == iw) imem_rdata = in;
        ic++;
      end
      if (st == 3'd4) begin
        dmem_ready = (dc == dw);
        dc++;
      end
      #1;
      o.cycles++;
      o.hist = {o.hist[27:0], 1'b0, state_o};
      if (imem_req) o.n_ireq++;
      if (dmem_req) o.n_dreq++;
      if (dmem_req && dmem_we) o.n_dwe++;
      if (rf_we) o.n_rfwe++;
      if (pc_we) begin o.n_pcwe++; o.pcsel = pc_sel; end
      if (instret) o.n_inst++;
      if (state_o != 3'd1 && {imm_sel, alu_a_sel, alu_b_sel, wb_sel} !== {e.imm, e.a, e.b, e.wb})
        o.sel_bad++;
      if (instret || state_o == 3'd6) begin done = 1'b1; break; end
    end
    o.tmo = ~done;
    o.ir  = ir_o;
  endtask

  task automatic test_reset();
    #3;
    n_chk++;
    if ({imem_req, dmem_req, dmem_we, ir_o, imm_sel, alu_a_sel, alu_b_sel, wb_sel, rf_we,
         pc_we, pc_sel, instret, illegal, bus_err, state_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got state %0d ir %h, required all zero", state_o, ir_o);
    end
    do_reset();
    #1;
    n_chk++;
    if (state_o !== 3'd0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: got state %0d, required 0", state_o);
    end
    @(negedge clk); #1;
    n_chk++;
    if (state_o !== 3'd1 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL idle_to_fetch: got state %0d req %0b, required 1/1", state_o, imem_req);
    end
  endtask

  task automatic test_addi();
    exp_t e; obs_t o;
    do_reset();
    e = model(32'h00500093, 0, 0, 1'b0);
    run_instr(32'h00500093, 0, 0, 1'b0, e, o);
    n_chk++;
    if (o.hist !== 32'h1235 || o.cycles != 4) begin
      n_fail++; $display("FAIL addi_seq: got hist %h cycles %0d, required 1235/4", o.hist, o.cycles);
    end
    n_chk++;
    if (o.n_rfwe != 1 || o.n_pcwe != 1 || o.n_inst != 1 || o.pcsel !== 1'b0 || o.sel_bad != 0) begin
      n_fail++; $display("FAIL addi_ctrl: got rfwe %0d pcwe %0d inst %0d pcsel %0b bad %0d, required 1 1 1 0 0",
                         o.n_rfwe, o.n_pcwe, o.n_inst, o.pcsel, o.sel_bad);
    end
    e = model(32'h00500093, 4, 0, 1'b0);
    run_instr(32'h00500093, 4, 0, 1'b0, e, o);
    n_chk++;
    if (o.cycles != 8 || o.n_ireq != 5 || bus_err !== 1'b0 || o.tmo) begin
      n_fail++; $display("FAIL ready_beats_timeout: got cycles %0d ireq %0d bus_err %0b, required 8 5 0",
                         o.cycles, o.n_ireq, bus_err);
    end
  endtask

  task automatic test_branch();
    exp_t e; obs_t o;
    e = model(32'h00000463, 0, 0, 1'b1);
    run_instr(32'h00000463, 0, 0, 1'b1, e, o);
    n_chk++;
    if (o.hist !== 32'h123 || o.pcsel !== 1'b1 || o.n_inst != 1 || o.n_rfwe != 0 || o.sel_bad != 0) begin
      n_fail++; $display("FAIL beq_taken: got hist %h pcsel %0b inst %0d rfwe %0d bad %0d, required 123 1 1 0 0",
                         o.hist, o.pcsel, o.n_inst, o.n_rfwe, o.sel_bad);
    end
    @(negedge clk); #1;
    n_chk++;
    if (state_o !== 3'd1) begin
      n_fail++; $display("FAIL beq_next_fetch: got state %0d, required 1", state_o);
    end
  endtask

  task automatic test_load_store_jal();
    exp_t e; obs_t o;
    do_reset();
    e = model(32'h0000A103, 0, 3, 1'b0);
    run_instr(32'h0000A103, 0, 3, 1'b0, e, o);
    n_chk++;
    if (o.hist !== 32'h12344445 || o.cycles != 8 || o.n_dreq != 4 || o.n_dwe != 0 || o.n_rfwe != 1 || o.sel_bad != 0) begin
      n_fail++; $display("FAIL lw_wait3: got hist %h cycles %0d dreq %0d dwe %0d rfwe %0d bad %0d",
                         o.hist, o.cycles, o.n_dreq, o.n_dwe, o.n_rfwe, o.sel_bad);
    end
    e = model(32'h0020A223, 0, 0, 1'b0);
    run_instr(32'h0020A223, 0, 0, 1'b0, e, o);
    n_chk++;
    if (o.cycles != 4 || o.n_dwe != 1 || o.n_rfwe != 0 || o.n_inst != 1 || o.sel_bad != 0) begin
      n_fail++; $display("FAIL sw: got cycles %0d dwe %0d rfwe %0d inst %0d bad %0d, required 4 1 0 1 0",
                         o.cycles, o.n_dwe, o.n_rfwe, o.n_inst, o.sel_bad);
    end
    e = model(32'h0000006F, 0, 0, 1'b0);
    run_instr(32'h0000006F, 0, 0, 1'b0, e, o);
    n_chk++;
    if (o.cycles != 4 || o.n_rfwe != 0 || o.pcsel !== 1'b1 || o.sel_bad != 0) begin
      n_fail++; $display("FAIL jal_x0: got cycles %0d rfwe %0d pcsel %0b bad %0d, required 4 0 1 0",
                         o.cycles, o.n_rfwe, o.pcsel, o.sel_bad);
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [8];
    logic [31:0] r, in;
    logic [4:0]  rd;
    logic        bc;
    int          iw, dw;
    exp_t e; obs_t o;
    ops = '{7'h63, 7'h03, 7'h23, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67};
    do_reset();
    for (int n = 0; n < 40; n++) begin
      r  = $urandom;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : r[11:7];
      in = {r[31:12], rd, ops[$urandom_range(0, 7)]};
      iw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      bc = 1'($urandom_range(0, 1));
      e  = model(in, iw, dw, bc);
      run_instr(in, iw, dw, bc, e, o);
      n_chk++;
      if (o.tmo || o.cycles != e.cycles || o.n_ireq != e.n_ireq || o.n_dreq != e.n_dreq) begin
        n_fail++; $display("FAIL rand_timing %h: got cycles %0d ireq %0d dreq %0d, required %0d %0d %0d",
                           in, o.cycles, o.n_ireq, o.n_dreq, e.cycles, e.n_ireq, e.n_dreq);
      end
      n_chk++;
      if (o.n_dwe != e.n_dwe || o.n_rfwe != e.n_rfwe || o.n_pcwe != 1 || o.n_inst != 1 || o.pcsel !== e.pcsel) begin
        n_fail++; $display("FAIL rand_strobes %h: got dwe %0d rfwe %0d pcwe %0d inst %0d pcsel %0b, required %0d %0d 1 1 %0b",
                           in, o.n_dwe, o.n_rfwe, o.n_pcwe, o.n_inst, o.pcsel, e.n_dwe, e.n_rfwe, e.pcsel);
      end
      n_chk++;
      if (o.sel_bad != 0 || o.ir !== in || illegal !== 1'b0 || bus_err !== 1'b0) begin
        n_fail++; $display("FAIL rand_decode %h: got bad %0d ir %h ill %0b berr %0b, required 0 %h 0 0",
                           in, o.sel_bad, o.ir, illegal, bus_err, in);
      end
    end
  endtask

  task automatic test_illegal(input logic [31:0] in);
    int n;
    do_reset();
    @(negedge clk); imem_ready = 1'b1; imem_rdata = in;
    @(negedge clk); imem_ready = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if (state_o !== 3'd6 || illegal !== 1'b1 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL illegal_%h: got state %0d ill %0b berr %0b, required 6 1 0", in, state_o, illegal, bus_err);
    end
    n = 0;
    repeat (10) begin
      @(negedge clk);
      imem_ready = 1'($urandom_range(0, 1)); dmem_ready = 1'($urandom_range(0, 1));
      #1;
      if (imem_req || dmem_req || pc_we || instret || rf_we || state_o != 3'd6 || illegal !== 1'b1) n++;
    end
    n_chk++;
    if (n != 0) begin
      n_fail++; $display("FAIL halt_sticky_%h: got %0d active cycles, required 0", in, n);
    end
  endtask

  task automatic test_timeout();
    int n;
    exp_t e; obs_t o;
    do_reset();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); imem_ready = 1'b0; dmem_ready = 1'($urandom_range(0, 1));
      #1;
      if (state_o == 3'd6) break;
      if (imem_req) n++;
    end
    n_chk++;
    if (n != 5 || bus_err !== 1'b1 || state_o !== 3'd6 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL imem_timeout: got %0d fetch cycles berr %0b state %0d, required 5 1 6", n, bus_err, state_o);
    end
    do_reset();
    @(negedge clk); imem_ready = 1'b1; imem_rdata = 32'h0000A103;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); imem_ready = 1'b0; dmem_ready = 1'b0;
      #1;
      if (state_o == 3'd6) break;
      if (dmem_req) n++;
    end
    n_chk++;
    if (n != 5 || bus_err !== 1'b1 || state_o !== 3'd6) begin
      n_fail++; $display("FAIL dmem_timeout: got %0d mem cycles berr %0b state %0d, required 5 1 6", n, bus_err, state_o);
    end
    do_reset();
    e = model(32'h00500093, 0, 0, 1'b0);
    run_instr(32'h00500093, 0, 0, 1'b0, e, o);
    @(negedge clk); imem_ready = 1'b0;
    @(negedge clk); imem_ready = 1'b0;
    #1;
    n_chk++;
    if (ir_o !== 32'h00500093 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_wait: got ir %h req %0b, required 00500093 1", ir_o, imem_req);
    end
    #1; rst_n = 1'b0; #1;
    n_chk++;
    if ({imem_req, dmem_req, dmem_we, ir_o, imm_sel, alu_a_sel, alu_b_sel, wb_sel, rf_we,
         pc_we, pc_sel, instret, illegal, bus_err, state_o} !== '0) begin
      n_fail++; $display("FAIL mid_wait_reset: got state %0d ir %h req %0b, required all zero", state_o, ir_o, imem_req);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_chk++;
    if (state_o !== 3'd1 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL restart_after_reset: got state %0d, required 1", state_o);
    end
  endtask

  initial begin
    imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = '0; branch_cond = 1'b0;
    test_reset();
    test_addi();
    test_branch();
    test_load_store_jal();
    test_random();
    test_illegal(32'h0000007F);
    test_illegal(32'h00000000);
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
